// File: rtl/cimg_pkg.sv
// Shared types and helpers for the ping-pong stripe-buffer write controller.
package cimg_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2,
        FLUSH      = 2'd3
    } cimg_state_t;

    // Bit b set: bank b is owned by the CPU and must not be written.
    typedef logic [1:0] bank_own_t;

    function automatic int pack_of(input int pix_w, input int word_w);
        return word_w / pix_w;
    endfunction

endpackage

// File: rtl/cimg_pix_packer.sv
// Packs PIX_W-bit pixels into WORD_W-bit words, first pixel in the low slot.
// word/word_valid are combinational so the caller can register the write.
module cimg_pix_packer
    import cimg_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [PIX_W-1:0]  din,
    input  logic              flush,
    input  logic              clear,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);
    localparam int PACK  = pack_of(PIX_W, WORD_W);
    localparam int CNT_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PACK - 1);

    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              flush_hit;

    // Unused slots of shreg are always zero, which gives the padding for free.
    assign flush_hit = flush && (cnt != '0);

    always_comb begin
        word = shreg;
        if (push && !flush_hit)
            word[cnt*PIX_W +: PIX_W] = din;
    end

    assign word_valid = !clear && (flush_hit || (push && cnt == LAST));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (flush_hit) begin
            // A pixel arriving with the flush starts the next word.
            shreg <= '0;
            cnt   <= '0;
            if (push) begin
                shreg[PIX_W-1:0] <= din;
                cnt              <= CNT_W'(1);
            end
        end else if (push) begin
            if (cnt == LAST) begin
                shreg <= '0;
                cnt   <= '0;
            end else begin
                shreg[cnt*PIX_W +: PIX_W] <= din;
                cnt                       <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cimg_stripe_ctrl.sv
// Ping-pong stripe-buffer write controller: packs pixels, writes two BRAM banks.
// Build option CIMG_LINE_PAD_EN: pad and write the partial word on each line_begin.
module cimg_stripe_ctrl
    import cimg_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 14,
    parameter int DROP_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sensor_state,
    input  logic [PIX_W-1:0]  sensor_din,
    input  logic              frame_begin,
    input  logic              line_begin,
    input  logic              frame_state,
    input  logic              line_state,
    input  logic [ADDR_W-1:0] stripe_words,
    input  logic              bank_ack,
    input  logic              ack_bank,
    output logic              buf_wren,
    output logic [ADDR_W:0]   buf_wraddr,
    output logic [WORD_W-1:0] buf_wrdata,
    output logic              interrupt,
    output logic              irq_bank,
    output logic [ADDR_W:0]   irq_words,
    output logic              frame_done,
    output logic              miss_state,
    output logic [DROP_W-1:0] drop_count,
    output cimg_state_t       state_dbg
);
    // Handshake: the pixel stream has no backpressure; a pixel is taken on any
    // cycle it is qualified, and buf_wren is a one-cycle write with no ready.
    cimg_state_t       state;
    logic              wr_bank;
    bank_own_t         own;
    bank_own_t         own_eff;
    bank_own_t         own_next;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] idx_after;
    logic [ADDR_W:0]   full_words;
    logic              fs_q;

    logic              accept, restart, in_flush, pad_line;
    logic              pk_push, pk_flush, pk_clear, pk_valid;
    logic [WORD_W-1:0] pk_word;
    logic              target_busy, do_write, do_drop, hit_full, eof_hand, handover;

    assign accept   = enable && (state == CAPTURE) && sensor_state && frame_state && line_state;
    assign restart  = enable && (state == CAPTURE) && frame_begin;
    assign in_flush = enable && (state == FLUSH);

`ifdef CIMG_LINE_PAD_EN
    assign pad_line = enable && (state == CAPTURE) && line_begin;
`else
    logic unused_line_begin;
    assign unused_line_begin = line_begin;
    assign pad_line          = 1'b0;
`endif

    assign pk_push  = accept && !restart;
    assign pk_flush = in_flush || pad_line;
    assign pk_clear = !enable || restart;

    cimg_pix_packer #(
        .PIX_W  (PIX_W),
        .WORD_W (WORD_W)
    ) u_packer (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (pk_push),
        .din        (sensor_din),
        .flush      (pk_flush),
        .clear      (pk_clear),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    // The CPU release is applied before this cycle's write/drop decision.
    always_comb begin
        own_eff = own;
        if (bank_ack)
            own_eff[ack_bank] = 1'b0;
        own_next = own_eff;
        if (handover)
            own_next[wr_bank] = 1'b1;
    end

    assign target_busy = own_eff[wr_bank];
    assign do_write    = pk_valid && !target_busy;
    assign do_drop     = pk_valid && target_busy;
    assign hit_full    = do_write && (word_idx == (stripe_words - 1'b1));
    assign idx_after   = do_write ? (word_idx + ADDR_W'(1)) : word_idx;
    assign eof_hand    = in_flush && !hit_full && !target_busy && (idx_after != '0);
    assign handover    = hit_full || eof_hand;
    assign full_words  = (stripe_words == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, stripe_words};
    assign state_dbg   = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_bank    <= 1'b0;
            own        <= '0;
            word_idx   <= '0;
            fs_q       <= 1'b0;
            buf_wren   <= 1'b0;
            buf_wraddr <= '0;
            buf_wrdata <= '0;
            interrupt  <= 1'b0;
            irq_bank   <= 1'b0;
            irq_words  <= '0;
            frame_done <= 1'b0;
            miss_state <= 1'b0;
            drop_count <= '0;
        end else begin
            fs_q       <= frame_state;
            own        <= own_next;
            buf_wren   <= 1'b0;
            interrupt  <= 1'b0;
            frame_done <= 1'b0;

            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:       state <= WAIT_FRAME;
                    WAIT_FRAME: if (frame_begin) state <= CAPTURE;
                    CAPTURE:    if (fs_q && !frame_state) state <= FLUSH;
                    FLUSH:      state <= WAIT_FRAME;
                    default:    state <= IDLE;
                endcase
            end

            if (do_write) begin
                buf_wren   <= 1'b1;
                buf_wraddr <= {wr_bank, word_idx};
                buf_wrdata <= pk_word;
            end

            if (!enable || restart || handover)
                word_idx <= '0;
            else if (do_write)
                word_idx <= idx_after;

            if (handover) begin
                interrupt  <= 1'b1;
                irq_bank   <= wr_bank;
                irq_words  <= hit_full ? full_words : {1'b0, idx_after};
                frame_done <= in_flush;
                wr_bank    <= ~wr_bank;
            end

            if (frame_begin && !restart)
                miss_state <= 1'b0;
            if (do_drop || restart)
                miss_state <= 1'b1;
            if (do_drop && (drop_count != '1))
                drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cimg_stripe_ctrl.sv
// Directed testbench for cimg_stripe_ctrl (default parameters, stripe of 4 or 8 words).
module tb_cimg_stripe_ctrl;
    import cimg_pkg::*;

    localparam int PIX_W  = 8;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 14;
    localparam int DROP_W = 16;

    logic              clock;
    logic              reset_n;
    logic              enable;
    logic              sensor_state;
    logic [PIX_W-1:0]  sensor_din;
    logic              frame_begin;
    logic              line_begin;
    logic              frame_state;
    logic              line_state;
    logic [ADDR_W-1:0] stripe_words;
    logic              bank_ack;
    logic              ack_bank;
    logic              buf_wren;
    logic [ADDR_W:0]   buf_wraddr;
    logic [WORD_W-1:0] buf_wrdata;
    logic              interrupt;
    logic              irq_bank;
    logic [ADDR_W:0]   irq_words;
    logic              frame_done;
    logic              miss_state;
    logic [DROP_W-1:0] drop_count;
    cimg_state_t       state_dbg;

    // Write entry {addr, data}; interrupt entry {frame_done, bank, words, wren, addr}.
    logic [46:0] exp_q[$];
    logic [46:0] obs_q[$];
    logic [32:0] irq_exp_q[$];
    logic [32:0] irq_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    cimg_stripe_ctrl #(
        .PIX_W  (PIX_W),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .DROP_W (DROP_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .sensor_state (sensor_state),
        .sensor_din   (sensor_din),
        .frame_begin  (frame_begin),
        .line_begin   (line_begin),
        .frame_state  (frame_state),
        .line_state   (line_state),
        .stripe_words (stripe_words),
        .bank_ack     (bank_ack),
        .ack_bank     (ack_bank),
        .buf_wren     (buf_wren),
        .buf_wraddr   (buf_wraddr),
        .buf_wrdata   (buf_wrdata),
        .interrupt    (interrupt),
        .irq_bank     (irq_bank),
        .irq_words    (irq_words),
        .frame_done   (frame_done),
        .miss_state   (miss_state),
        .drop_count   (drop_count),
        .state_dbg    (state_dbg)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (buf_wren)
                obs_q.push_back({buf_wraddr, buf_wrdata});
            if (interrupt)
                irq_q.push_back({frame_done, irq_bank, irq_words, buf_wren,
                                 buf_wren ? buf_wraddr : 15'h0000});
        end
    end

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input logic [ADDR_W-1:0] sw);
        reset_n = 1'b0; enable = 1'b0; sensor_state = 1'b0; sensor_din = '0;
        frame_begin = 1'b0; line_begin = 1'b0; frame_state = 1'b0; line_state = 1'b0;
        stripe_words = sw; bank_ack = 1'b0; ack_bank = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        exp_q.delete(); obs_q.delete(); irq_exp_q.delete(); irq_q.delete();
    endtask

    task automatic start_frame;
        enable = 1'b1;
        cyc(1);
        frame_begin = 1'b1; frame_state = 1'b1; line_state = 1'b1;
        cyc(1);
        frame_begin = 1'b0;
    endtask

    task automatic end_frame;
        frame_state = 1'b0; line_state = 1'b0;
        cyc(4);
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic ack, input logic ackb);
        sensor_state = 1'b1; sensor_din = d; bank_ack = ack; ack_bank = ackb;
        cyc(1);
        sensor_state = 1'b0; bank_ack = 1'b0;
    endtask

    task automatic send_run(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++)
            send_pixel(base + 8'(i), 1'b0, 1'b0);
    endtask

    // Tests
    task automatic test_reset;
        do_reset(14'd4);
        reset_n = 1'b0;
        cyc(1);
        n_cmp++; if (buf_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %b want 0", buf_wren); end
        n_cmp++; if (buf_wraddr !== 15'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", buf_wraddr); end
        n_cmp++; if (buf_wrdata !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", buf_wrdata); end
        n_cmp++; if (interrupt !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got irq=%b fd=%b want 0", interrupt, frame_done); end
        n_cmp++; if (irq_bank !== 1'b0 || irq_words !== 15'h0) begin n_fail++; $display("FAIL rst_irqinfo: got bank=%b words=%h want 0", irq_bank, irq_words); end
        n_cmp++; if (miss_state !== 1'b0 || drop_count !== 16'h0) begin n_fail++; $display("FAIL rst_drop: got miss=%b cnt=%h want 0", miss_state, drop_count); end
        n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", state_dbg, IDLE); end
        reset_n = 1'b1;
        cyc(3);
        n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL rst_idle_hold: got %0d want %0d", state_dbg, IDLE); end
        enable = 1'b1;
        cyc(1);
        n_cmp++; if (state_dbg !== WAIT_FRAME) begin n_fail++; $display("FAIL rst_wait: got %0d want %0d", state_dbg, WAIT_FRAME); end
    endtask

    task automatic test_fill_bank;
        do_reset(14'd4);
        start_frame();
        send_run(8'h00, 20);
        cyc(2);
        exp_q.push_back({15'h0000, 32'h03020100});
        exp_q.push_back({15'h0001, 32'h07060504});
        exp_q.push_back({15'h0002, 32'h0B0A0908});
        exp_q.push_back({15'h0003, 32'h0F0E0D0C});
        exp_q.push_back({15'h4000, 32'h13121110});
        irq_exp_q.push_back({1'b0, 1'b0, 15'd4, 1'b1, 15'h0003});
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fill_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fill_wr%0d: got %h want %h", i, obs_q[i], exp_q[i]); end end
        n_cmp++; if (irq_q.size() != irq_exp_q.size()) begin n_fail++; $display("FAIL fill_irq_count: got %0d want %0d", irq_q.size(), irq_exp_q.size()); end
        foreach (irq_exp_q[i]) if (i < irq_q.size()) begin n_cmp++; if (irq_q[i] !== irq_exp_q[i]) begin n_fail++; $display("FAIL fill_irq%0d: got %h want %h", i, irq_q[i], irq_exp_q[i]); end end
        n_cmp++; if (state_dbg !== CAPTURE) begin n_fail++; $display("FAIL fill_state: got %0d want %0d", state_dbg, CAPTURE); end
    endtask

    task automatic test_drop;
        do_reset(14'd4);
        start_frame();
        send_run(8'h00, 40);
        cyc(2);
        n_cmp++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL drop_cnt2: got %0d want 2", drop_count); end
        n_cmp++; if (miss_state !== 1'b1) begin n_fail++; $display("FAIL drop_miss: got %b want 1", miss_state); end
        // Releasing bank 1 does not help: bank 0 is the write target.
        send_pixel(8'h40, 1'b1, 1'b1);
        send_run(8'h41, 3);
        cyc(2);
        n_cmp++; if (drop_count !== 16'd3) begin n_fail++; $display("FAIL drop_cnt3: got %0d want 3", drop_count); end
        bank_ack = 1'b1; ack_bank = 1'b0;
        cyc(1);
        bank_ack = 1'b0;
        send_run(8'h30, 4);
        cyc(2);
        end_frame();
        exp_q.push_back({15'h0000, 32'h03020100});
        exp_q.push_back({15'h0001, 32'h07060504});
        exp_q.push_back({15'h0002, 32'h0B0A0908});
        exp_q.push_back({15'h0003, 32'h0F0E0D0C});
        exp_q.push_back({15'h4000, 32'h13121110});
        exp_q.push_back({15'h4001, 32'h17161514});
        exp_q.push_back({15'h4002, 32'h1B1A1918});
        exp_q.push_back({15'h4003, 32'h1F1E1D1C});
        exp_q.push_back({15'h0000, 32'h33323130});
        irq_exp_q.push_back({1'b0, 1'b0, 15'd4, 1'b1, 15'h0003});
        irq_exp_q.push_back({1'b0, 1'b1, 15'd4, 1'b1, 15'h4003});
        irq_exp_q.push_back({1'b1, 1'b0, 15'd1, 1'b0, 15'h0000});
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL drop_wr%0d: got %h want %h", i, obs_q[i], exp_q[i]); end end
        n_cmp++; if (irq_q.size() != irq_exp_q.size()) begin n_fail++; $display("FAIL drop_irq_count: got %0d want %0d", irq_q.size(), irq_exp_q.size()); end
        foreach (irq_exp_q[i]) if (i < irq_q.size()) begin n_cmp++; if (irq_q[i] !== irq_exp_q[i]) begin n_fail++; $display("FAIL drop_irq%0d: got %h want %h", i, irq_q[i], irq_exp_q[i]); end end
        n_cmp++; if (miss_state !== 1'b1) begin n_fail++; $display("FAIL drop_miss_sticky: got %b want 1", miss_state); end
        start_frame();
        n_cmp++; if (miss_state !== 1'b0) begin n_fail++; $display("FAIL drop_miss_clear: got %b want 0", miss_state); end
        n_cmp++; if (drop_count !== 16'd3) begin n_fail++; $display("FAIL drop_cnt_keep: got %0d want 3", drop_count); end
    endtask

    task automatic test_ack_coincide;
        do_reset(14'd4);
        start_frame();
        send_run(8'h00, 31);
        send_pixel(8'h1F, 1'b1, 1'b0);
        send_run(8'h20, 4);
        cyc(2);
        exp_q.push_back({15'h0000, 32'h03020100});
        exp_q.push_back({15'h0001, 32'h07060504});
        exp_q.push_back({15'h0002, 32'h0B0A0908});
        exp_q.push_back({15'h0003, 32'h0F0E0D0C});
        exp_q.push_back({15'h4000, 32'h13121110});
        exp_q.push_back({15'h4001, 32'h17161514});
        exp_q.push_back({15'h4002, 32'h1B1A1918});
        exp_q.push_back({15'h4003, 32'h1F1E1D1C});
        exp_q.push_back({15'h0000, 32'h23222120});
        irq_exp_q.push_back({1'b0, 1'b0, 15'd4, 1'b1, 15'h0003});
        irq_exp_q.push_back({1'b0, 1'b1, 15'd4, 1'b1, 15'h4003});
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ack_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ack_wr%0d: got %h want %h", i, obs_q[i], exp_q[i]); end end
        n_cmp++; if (irq_q.size() != irq_exp_q.size()) begin n_fail++; $display("FAIL ack_irq_count: got %0d want %0d", irq_q.size(), irq_exp_q.size()); end
        foreach (irq_exp_q[i]) if (i < irq_q.size()) begin n_cmp++; if (irq_q[i] !== irq_exp_q[i]) begin n_fail++; $display("FAIL ack_irq%0d: got %h want %h", i, irq_q[i], irq_exp_q[i]); end end
        n_cmp++; if (drop_count !== 16'd0 || miss_state !== 1'b0) begin n_fail++; $display("FAIL ack_nodrop: got cnt=%0d miss=%b want 0/0", drop_count, miss_state); end
    endtask

    task automatic test_eof;
        do_reset(14'd4);
        start_frame();
        send_run(8'h00, 6);
        end_frame();
        n_cmp++; if (state_dbg !== WAIT_FRAME) begin n_fail++; $display("FAIL eof_state: got %0d want %0d", state_dbg, WAIT_FRAME); end
        // Empty frame: nothing written, so no interrupt and no frame_done.
        start_frame();
        end_frame();
        exp_q.push_back({15'h0000, 32'h03020100});
        exp_q.push_back({15'h0001, 32'h00000504});
        irq_exp_q.push_back({1'b1, 1'b0, 15'd2, 1'b1, 15'h0001});
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL eof_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL eof_wr%0d: got %h want %h", i, obs_q[i], exp_q[i]); end end
        n_cmp++; if (irq_q.size() != irq_exp_q.size()) begin n_fail++; $display("FAIL eof_irq_count: got %0d want %0d", irq_q.size(), irq_exp_q.size()); end
        foreach (irq_exp_q[i]) if (i < irq_q.size()) begin n_cmp++; if (irq_q[i] !== irq_exp_q[i]) begin n_fail++; $display("FAIL eof_irq%0d: got %h want %h", i, irq_q[i], irq_exp_q[i]); end end
        n_cmp++; if (state_dbg !== WAIT_FRAME) begin n_fail++; $display("FAIL eof_state2: got %0d want %0d", state_dbg, WAIT_FRAME); end
    endtask

    task automatic test_restart;
        do_reset(14'd4);
        start_frame();
        send_run(8'h00, 6);
        frame_begin = 1'b1;
        cyc(1);
        frame_begin = 1'b0;
        send_run(8'h10, 4);
        cyc(2);
        exp_q.push_back({15'h0000, 32'h03020100});
        exp_q.push_back({15'h0000, 32'h13121110});
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_fr_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_fr_wr%0d: got %h want %h", i, obs_q[i], exp_q[i]); end end
        n_cmp++; if (irq_q.size() != 0) begin n_fail++; $display("FAIL rst_fr_irq: got %0d want 0", irq_q.size()); end
        n_cmp++; if (miss_state !== 1'b1) begin n_fail++; $display("FAIL rst_fr_miss: got %b want 1", miss_state); end
        n_cmp++; if (state_dbg !== CAPTURE) begin n_fail++; $display("FAIL rst_fr_state: got %0d want %0d", state_dbg, CAPTURE); end
    endtask

    task automatic test_line;
        do_reset(14'd8);
        start_frame();
        for (int l = 0; l < 3; l++) begin
            line_begin = 1'b1;
            cyc(1);
            line_begin = 1'b0;
            if (l < 2)
                send_run(8'(l * 5), 5);
        end
        cyc(2);
        end_frame();
`ifdef CIMG_LINE_PAD_EN
        exp_q.push_back({15'h0000, 32'h03020100});
        exp_q.push_back({15'h0001, 32'h00000004});
        exp_q.push_back({15'h0002, 32'h08070605});
        exp_q.push_back({15'h0003, 32'h00000009});
        irq_exp_q.push_back({1'b1, 1'b0, 15'd4, 1'b0, 15'h0000});
`else
        exp_q.push_back({15'h0000, 32'h03020100});
        exp_q.push_back({15'h0001, 32'h07060504});
        exp_q.push_back({15'h0002, 32'h00000908});
        irq_exp_q.push_back({1'b1, 1'b0, 15'd3, 1'b1, 15'h0002});
`endif
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL line_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL line_wr%0d: got %h want %h", i, obs_q[i], exp_q[i]); end end
        n_cmp++; if (irq_q.size() != irq_exp_q.size()) begin n_fail++; $display("FAIL line_irq_count: got %0d want %0d", irq_q.size(), irq_exp_q.size()); end
        foreach (irq_exp_q[i]) if (i < irq_q.size()) begin n_cmp++; if (irq_q[i] !== irq_exp_q[i]) begin n_fail++; $display("FAIL line_irq%0d: got %h want %h", i, irq_q[i], irq_exp_q[i]); end end
    endtask

    task automatic test_disable;
        do_reset(14'd4);
        start_frame();
        send_run(8'h00, 4);
        // The first word's write strobe is up right now; reset must clear it at once.
        reset_n = 1'b0;
        #1;
        n_cmp++; if (buf_wren !== 1'b0 || buf_wrdata !== 32'h0 || buf_wraddr !== 15'h0) begin n_fail++; $display("FAIL dis_async: got wren=%b data=%h addr=%h want 0", buf_wren, buf_wrdata, buf_wraddr); end
        n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL dis_async_state: got %0d want %0d", state_dbg, IDLE); end
        cyc(1);
        reset_n = 1'b1;
        start_frame();
        send_run(8'h10, 6);
        enable = 1'b0;
        cyc(1);
        n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL dis_idle: got %0d want %0d", state_dbg, IDLE); end
        cyc(3);
        exp_q.push_back({15'h0000, 32'h13121110});
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL dis_wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL dis_wr%0d: got %h want %h", i, obs_q[i], exp_q[i]); end end
        n_cmp++; if (irq_q.size() != 0) begin n_fail++; $display("FAIL dis_irq: got %0d want 0", irq_q.size()); end
    endtask

    initial begin
        test_reset();
        test_fill_bank();
        test_drop();
        test_ack_coincide();
        test_eof();
        test_restart();
        test_line();
        test_disable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
